// File: rtl/oldland_tlb_walker_if.sv
// Signal bundle for the oldland two-level page-table walker: miss request,
// word-read bus master, TLB load port and walk status.
interface oldland_tlb_walker_if;
   logic        ptbr_wr;
   logic [19:0] ptbr_data;
   logic        miss;
   logic [19:0] miss_virt;
   logic [31:0] m_addr;
   logic        m_rd;
   logic [31:0] m_data;
   logic        m_ack;
   logic        m_err;
   logic [31:0] load_data;
   logic        load_virt;
   logic        load_phys;
   logic        busy;
   logic        done;
   logic        fault;
   logic [31:0] fault_addr;

   modport master (
      input  ptbr_wr, ptbr_data, miss, miss_virt, m_data, m_ack, m_err,
      output m_addr, m_rd, load_data, load_virt, load_phys, busy, done, fault, fault_addr
   );

   modport slave (
      output ptbr_wr, ptbr_data, miss, miss_virt, m_data, m_ack, m_err,
      input  m_addr, m_rd, load_data, load_virt, load_phys, busy, done, fault, fault_addr
   );
endinterface

// File: rtl/oldland_tlb_walker.sv
// Two-level page-table walker: reads the L1 and L2 entries for a missing VPN,
// then writes the virtual and physical halves of the new TLB entry.
module oldland_tlb_walker #(
   parameter int timeout_cycles = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   oldland_tlb_walker_if.master bus
);
   typedef enum logic [2:0] {IDLE, L1_RD, L2_RD, LOAD_V, LOAD_P, DONE, FAULT} state_t;

   // Last wait count at which a missing response still counts as "in time".
   localparam logic [7:0] wait_last = 8'(timeout_cycles - 1);

   state_t      state_reg;
   logic [19:0] ptbr_reg;
   logic [19:0] vpn_reg;
   logic [19:0] pte_frame_reg;
   logic [7:0]  wait_reg;
   logic [31:0] m_addr_reg;
   logic [31:0] load_data_reg;
   logic [31:0] fault_addr_reg;
   logic        m_rd_reg;
   logic        load_virt_reg;
   logic        load_phys_reg;
   logic        busy_reg;
   logic        done_reg;
   logic        fault_reg;
   logic        rd_state;
   logic        timed_out;
   logic        rd_fail;

   assign rd_state  = (state_reg == L1_RD) || (state_reg == L2_RD);
   assign timed_out = !bus.m_ack && !bus.m_err && (wait_reg == wait_last);
   // An error response wins over a simultaneous ack; an invalid entry faults too.
   assign rd_fail   = bus.m_err || (bus.m_ack && !bus.m_data[0]) || timed_out;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         ptbr_reg       <= '0;
         vpn_reg        <= '0;
         pte_frame_reg  <= '0;
         wait_reg       <= '0;
         m_rd_reg       <= 1'b0;
         m_addr_reg     <= '0;
         load_virt_reg  <= 1'b0;
         load_phys_reg  <= 1'b0;
         load_data_reg  <= '0;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
         fault_reg      <= 1'b0;
         fault_addr_reg <= '0;
      end else begin
         if (bus.ptbr_wr) begin
            ptbr_reg <= bus.ptbr_data;
         end
         load_virt_reg <= 1'b0;
         load_phys_reg <= 1'b0;
         load_data_reg <= '0;
         done_reg      <= 1'b0;
         fault_reg     <= 1'b0;

         if (rd_state && rd_fail) begin
            state_reg      <= FAULT;
            m_rd_reg       <= 1'b0;
            m_addr_reg     <= '0;
            fault_reg      <= 1'b1;
            fault_addr_reg <= {vpn_reg, 12'h000};
         end else begin
            case (state_reg)
               IDLE: begin
                  if (bus.miss) begin
                     state_reg  <= L1_RD;
                     vpn_reg    <= bus.miss_virt;
                     wait_reg   <= '0;
                     m_rd_reg   <= 1'b1;
                     m_addr_reg <= {ptbr_reg, 12'h000} + {20'h0, bus.miss_virt[19:10], 2'b00};
                     busy_reg   <= 1'b1;
                  end
               end
               L1_RD: begin
                  if (bus.m_ack) begin
                     state_reg  <= L2_RD;
                     wait_reg   <= '0;
                     m_addr_reg <= {bus.m_data[31:12], 12'h000} + {20'h0, vpn_reg[9:0], 2'b00};
                  end else begin
                     wait_reg <= wait_reg + 8'd1;
                  end
               end
               L2_RD: begin
                  if (bus.m_ack) begin
                     state_reg     <= LOAD_V;
                     m_rd_reg      <= 1'b0;
                     m_addr_reg    <= '0;
                     pte_frame_reg <= bus.m_data[31:12];
                     load_virt_reg <= 1'b1;
                     load_data_reg <= {vpn_reg, 8'h00, bus.m_data[3:0]};
                  end else begin
                     wait_reg <= wait_reg + 8'd1;
                  end
               end
               LOAD_V: begin
                  state_reg     <= LOAD_P;
                  load_phys_reg <= 1'b1;
                  load_data_reg <= {pte_frame_reg, 12'h000};
               end
               LOAD_P: begin
                  state_reg <= DONE;
                  done_reg  <= 1'b1;
               end
               default: begin
                  // DONE, FAULT and any unused encoding all settle back to IDLE.
                  state_reg  <= IDLE;
                  busy_reg   <= 1'b0;
                  m_rd_reg   <= 1'b0;
                  m_addr_reg <= '0;
               end
            endcase
         end
      end
   end

   assign bus.m_rd       = m_rd_reg;
   assign bus.m_addr     = m_addr_reg;
   assign bus.load_virt  = load_virt_reg;
   assign bus.load_phys  = load_phys_reg;
   assign bus.load_data  = load_data_reg;
   assign bus.busy       = busy_reg;
   assign bus.done       = done_reg;
   assign bus.fault      = fault_reg;
   assign bus.fault_addr = fault_addr_reg;
endmodule

// File: tb/tb_oldland_tlb_walker.sv
// Randomised scoreboard bench for oldland_tlb_walker: stimulus pushes predicted
// bus reads, loads and done/fault pulses; a negedge monitor pops and compares.
module tb_oldland_tlb_walker;
   localparam int T = 4;
   localparam int EV_RD = 0, EV_LV = 1, EV_LP = 2, EV_DONE = 3, EV_FAULT = 4;
   localparam int CK_RESET = 0, CK_QUIET = 1, CK_BUSY = 2;

   typedef struct { int kind; logic [31:0] value; int cyc; } ev_t;
   typedef struct { int kind; int cyc; } ck_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst_q = 1'b1;
   int   cyc = 0;

   oldland_tlb_walker_if bus();
   oldland_tlb_walker #(.timeout_cycles(T)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
   end

   logic [31:0] mem [logic [31:0]];
   logic [19:0] model_ptbr = '0;
   int          plan_w [2];
   int          plan_e [2];
   logic        force_ack = 1'b0;
   ev_t         exp_q [$];
   ck_t         ck_q [$];
   int          checks = 0;
   int          failures = 0;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'h0;
   endfunction

   function automatic string ev_name(input int k);
      case (k)
         EV_RD:   return "bus_read";
         EV_LV:   return "load_virt";
         EV_LP:   return "load_phys";
         EV_DONE: return "done";
         default: return "fault";
      endcase
   endfunction

   function automatic void push_ev(input int k, input logic [31:0] v, input int c);
      ev_t e;
      e.kind = k; e.value = v; e.cyc = c;
      exp_q.push_back(e);
   endfunction

   function automatic void push_ck(input int k, input int c);
      ck_t e;
      e.kind = k; e.cyc = c;
      ck_q.push_back(e);
   endfunction

   // Reference walk: each level is one read at entry address base*4096 + index*4.
   function automatic int predict(input logic [19:0] vpn, input logic [19:0] base, input int n,
                                  input int w0, input int e0, input int w1, input int e1);
      logic [31:0] a, ent;
      int t;
      int w [2];
      int e [2];
      w[0] = w0; w[1] = w1; e[0] = e0; e[1] = e1;
      a = {base, 12'h000} + 32'(vpn[19:10]) * 4;
      ent = '0;
      t = n + 1;
      for (int lvl = 0; lvl < 2; lvl++) begin
         push_ev(EV_RD, a, t);
         if (w[lvl] >= T) begin
            push_ev(EV_FAULT, {vpn, 12'h000}, t + T);
            return t + T;
         end
         t = t + w[lvl] + 1;
         ent = mem_rd(a);
         if (e[lvl] != 0 || ent[0] == 1'b0) begin
            push_ev(EV_FAULT, {vpn, 12'h000}, t);
            return t;
         end
         a = {ent[31:12], 12'h000} + 32'(vpn[9:0]) * 4;
      end
      push_ev(EV_LV, {vpn, 8'h00, ent[3:0]}, t);
      push_ev(EV_LP, {ent[31:12], 12'h000}, t + 1);
      push_ev(EV_DONE, 32'h0, t + 2);
      return t + 2;
   endfunction

   // Bus slave: per-read wait states and error kind come from plan_w/plan_e,
   // indexed by read number within the walk; junk acks while not reading.
   int rs_idx = 0, rs_cnt = 0, rs_k = 0;
   bit rs_busy = 1'b0;
   always @(negedge clk) begin
      bus.m_ack  = 1'b0;
      bus.m_err  = 1'b0;
      bus.m_data = $urandom;
      if (!bus.busy) rs_idx = 0;
      if (!bus.m_rd) begin
         rs_busy = 1'b0;
         if ($urandom_range(3) == 0) begin
            bus.m_ack = 1'b1;
            bus.m_err = ($urandom_range(7) == 0);
         end
      end else begin
         if (!rs_busy) begin
            rs_busy = 1'b1;
            rs_cnt  = 0;
         end
         rs_k = (rs_idx < 2) ? rs_idx : 1;
         if (rs_cnt == plan_w[rs_k]) begin
            bus.m_data = mem_rd(bus.m_addr);
            bus.m_ack  = (plan_e[rs_k] != 1);
            bus.m_err  = (plan_e[rs_k] != 0);
            rs_busy    = 1'b0;
            rs_idx++;
         end else begin
            rs_cnt++;
         end
      end
      if (force_ack) begin
         bus.m_ack  = 1'b1;
         bus.m_err  = 1'b0;
         bus.m_data = 32'h0000_0001;
      end
   end

   task automatic match(input int kind, input logic [31:0] value);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL unexpected_%s: got value=%h cycle=%0d, required no event", ev_name(kind), value, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.value !== value || e.cyc != cyc) begin
            failures++;
            $display("FAIL %s: got %s value=%h cycle=%0d, required %s value=%h cycle=%0d",
                     ev_name(e.kind), ev_name(kind), value, cyc, ev_name(e.kind), e.value, e.cyc);
         end else begin
            $display("txn %s value=%h cycle=%0d ok", ev_name(kind), value, cyc);
         end
      end
   endtask

   logic        prev_rd = 1'b0;
   logic [31:0] prev_addr = '0;
   logic [31:0] outs_quiet;
   ev_t         miss_e;
   ck_t         ck_e;
   always @(negedge clk) begin
      if (rst_q) begin
         prev_rd   = 1'b0;
         prev_addr = '0;
      end else begin
         if (bus.m_rd && (!prev_rd || bus.m_addr != prev_addr)) match(EV_RD, bus.m_addr);
         if (bus.load_virt) match(EV_LV, bus.load_data);
         if (bus.load_phys) match(EV_LP, bus.load_data);
         if (bus.done)      match(EV_DONE, 32'h0);
         if (bus.fault)     match(EV_FAULT, bus.fault_addr);
         prev_rd   = bus.m_rd;
         prev_addr = bus.m_addr;
         while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            miss_e = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_%s: got nothing by cycle=%0d, required value=%h at cycle=%0d",
                     ev_name(miss_e.kind), cyc, miss_e.value, miss_e.cyc);
         end
         checks++;
         if ((!bus.m_rd && bus.m_addr != 0) || (bus.load_virt && bus.load_phys) ||
             (!bus.load_virt && !bus.load_phys && bus.load_data != 0) ||
             ((bus.done || bus.fault) && bus.m_rd) || (bus.done && bus.fault)) begin
            failures++;
            $display("FAIL output_rules cycle=%0d: got m_rd=%b m_addr=%h lv=%b lp=%b load_data=%h done=%b fault=%b, required consistent strobes",
                     cyc, bus.m_rd, bus.m_addr, bus.load_virt, bus.load_phys, bus.load_data, bus.done, bus.fault);
         end
         outs_quiet = {26'h0, bus.busy, bus.m_rd, bus.load_virt, bus.load_phys, bus.done, bus.fault}
                      | bus.m_addr | bus.load_data;
         while (ck_q.size() > 0 && ck_q[0].cyc <= cyc) begin
            ck_e = ck_q.pop_front();
            checks++;
            if (ck_e.cyc != cyc) begin
               failures++;
               $display("FAIL check_skipped kind=%0d: got cycle=%0d, required cycle=%0d", ck_e.kind, cyc, ck_e.cyc);
            end else if (ck_e.kind == CK_BUSY) begin
               if (bus.busy !== 1'b1) begin
                  failures++;
                  $display("FAIL busy_in_walk cycle=%0d: got busy=%b, required 1", cyc, bus.busy);
               end
            end else if (outs_quiet != 0 || (ck_e.kind == CK_RESET && bus.fault_addr != 0)) begin
               failures++;
               $display("FAIL %s cycle=%0d: got busy=%b m_rd=%b m_addr=%h lv=%b lp=%b data=%h done=%b fault=%b fault_addr=%h, required all 0",
                        (ck_e.kind == CK_RESET) ? "reset_state" : "idle_quiet", cyc, bus.busy, bus.m_rd, bus.m_addr,
                        bus.load_virt, bus.load_phys, bus.load_data, bus.done, bus.fault, bus.fault_addr);
            end else begin
               $display("txn %s cycle=%0d ok", (ck_e.kind == CK_RESET) ? "reset_state" : "idle_quiet", cyc);
            end
         end
      end
   end

   task automatic write_ptbr(input logic [19:0] v);
      @(negedge clk);
      bus.ptbr_wr   = 1'b1;
      bus.ptbr_data = v;
      @(negedge clk);
      bus.ptbr_wr   = 1'b0;
      model_ptbr    = v;
   endtask

   task automatic do_walk(input logic [19:0] vpn, input int w0, input int e0, input int w1, input int e1,
                          input bit hold, input bit mid_wr, input logic [19:0] new_ptbr);
      int n, n2, last;
      plan_w[0] = w0; plan_e[0] = e0; plan_w[1] = w1; plan_e[1] = e1;
      @(negedge clk);
      n = cyc;
      bus.miss      = 1'b1;
      bus.miss_virt = vpn;
      last = predict(vpn, model_ptbr, n, w0, e0, w1, e1);
      push_ck(CK_BUSY, last);
      @(negedge clk);
      if (!hold) bus.miss = 1'b0;
      if (mid_wr) begin
         bus.ptbr_wr   = 1'b1;
         bus.ptbr_data = new_ptbr;
         model_ptbr    = new_ptbr;
      end
      @(negedge clk);
      bus.ptbr_wr = 1'b0;
      if (hold) begin
         n2   = last + 1;
         last = predict(vpn, model_ptbr, n2, w0, e0, w1, e1);
         push_ck(CK_BUSY, last);
         while (cyc < n2 + 1) @(negedge clk);
         bus.miss = 1'b0;
      end
      push_ck(CK_QUIET, last + 1);
      while (cyc < last + 1) @(negedge clk);
   endtask

   function automatic int rand_wait();
      return ($urandom_range(9) < 7) ? int'($urandom_range(2)) : int'($urandom_range(5, 3));
   endfunction

   function automatic int rand_err();
      int r;
      r = int'($urandom_range(19));
      return (r == 0) ? 1 : ((r == 1) ? 2 : 0);
   endfunction

   initial begin
      int n;
      bus.ptbr_wr = 1'b0; bus.ptbr_data = '0; bus.miss = 1'b0; bus.miss_virt = '0;
      plan_w[0] = 0; plan_w[1] = 0; plan_e[0] = 0; plan_e[1] = 0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      push_ck(CK_RESET, cyc + 1);
      @(negedge clk);

      // Reference walk, then the same walk with an invalid L1 entry.
      write_ptbr(20'h00010);
      mem[32'h0001_0400] = 32'h0002_0001;
      mem[32'h0002_048C] = 32'h0ABC_D00B;
      do_walk(20'h40123, 0, 0, 0, 0, 1'b0, 1'b0, '0);
      mem[32'h0001_0400] = 32'h0002_0000;
      do_walk(20'h40123, 0, 0, 0, 0, 1'b0, 1'b0, '0);
      mem[32'h0001_0400] = 32'h0002_0001;
      // Withheld ack, err+ack on L2, err alone on L1 after wait states.
      do_walk(20'h40123, 7, 0, 0, 0, 1'b0, 1'b0, '0);
      do_walk(20'h40123, 0, 0, 0, 2, 1'b0, 1'b0, '0);
      do_walk(20'h40123, 2, 1, 0, 0, 1'b0, 1'b0, '0);
      // Base written mid-walk: this walk keeps 0x00010, the next uses 0x00030.
      mem[32'h0003_0400] = 32'h0002_1001;
      mem[32'h0002_148C] = 32'h1234_5007;
      do_walk(20'h40123, 1, 0, 1, 0, 1'b0, 1'b1, 20'h00030);
      do_walk(20'h40123, 0, 0, 0, 0, 1'b0, 1'b0, '0);
      // Miss held high across the walk restarts right after the IDLE cycle.
      do_walk(20'h40123, 0, 0, 1, 0, 1'b1, 1'b0, '0);

      // Reset in the middle of an L2 read, with a late ack after it.
      write_ptbr(20'h00010);
      plan_w[0] = 0; plan_e[0] = 0; plan_w[1] = 6; plan_e[1] = 0;
      @(negedge clk);
      n = cyc;
      bus.miss = 1'b1;
      bus.miss_virt = 20'h40123;
      push_ev(EV_RD, 32'h0001_0400, n + 1);
      push_ev(EV_RD, 32'h0002_048C, n + 2);
      push_ck(CK_RESET, n + 4);
      for (int k = 5; k <= 8; k++) push_ck(CK_QUIET, n + k);
      @(negedge clk);
      bus.miss = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      force_ack = 1'b1;
      model_ptbr = '0;
      @(negedge clk);
      force_ack = 1'b0;
      while (cyc < n + 9) @(negedge clk);

      for (int i = 0; i < 40; i++) begin
         logic [19:0] vpn, fr;
         logic [31:0] l1a, l2a;
         vpn = 20'($urandom);
         if (i == 0 || $urandom_range(4) == 0) write_ptbr(20'($urandom_range(255, 1)));
         fr  = 20'($urandom_range(32'hFFFFF, 32'h01000));
         l1a = {model_ptbr, 12'h000} + 32'(vpn[19:10]) * 4;
         mem[l1a] = {fr, 11'($urandom), 1'($urandom_range(9) != 0)};
         l2a = {fr, 12'h000} + 32'(vpn[9:0]) * 4;
         mem[l2a] = {20'($urandom), 11'($urandom), 1'($urandom_range(9) != 0)};
         do_walk(vpn, rand_wait(), rand_err(), rand_wait(), rand_err(),
                 $urandom_range(7) == 0, $urandom_range(4) == 0, 20'($urandom_range(255, 1)));
         repeat ($urandom_range(2)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no end of stimulus by 2000000 time units, required completion");
      $fatal(1, "watchdog");
   end
endmodule
